// File: rtl/cpu_pkg.sv
// ----------------------------------------------------------------------------
// cpu_pkg
// Shared definitions for the 16-bit processor control path:
//   - opcode constants, including the ALU codes 0001-0110 that are passed
//     straight through to the ALU opcode input
//   - sequencer state encoding
//   - instruction field bit positions and field extraction helpers
// No ports; imported by instr_sequencer and reg_file_16x16.
// ----------------------------------------------------------------------------
package cpu_pkg;

    localparam int unsigned XLEN = 16;

    // Opcodes (instruction bits [15:12])
    localparam logic [3:0] OP_NOP   = 4'b0000;
    localparam logic [3:0] OP_ADD   = 4'b0001;
    localparam logic [3:0] OP_SUB   = 4'b0010;
    localparam logic [3:0] OP_AND   = 4'b0011;
    localparam logic [3:0] OP_OR    = 4'b0100;
    localparam logic [3:0] OP_XOR   = 4'b0101;
    localparam logic [3:0] OP_NOT   = 4'b0110;
    localparam logic [3:0] OP_LOAD  = 4'b0111;
    localparam logic [3:0] OP_STORE = 4'b1000;
    localparam logic [3:0] OP_LDI   = 4'b1001;
    localparam logic [3:0] OP_JMP   = 4'b1010;
    localparam logic [3:0] OP_BZ    = 4'b1011;
    localparam logic [3:0] OP_HALT  = 4'b1111;

    // Opcode driven to the ALU whenever no ALU operation is executing
    localparam logic [3:0] ALU_IDLE = 4'b0000;

    // Sequencer states
    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_FETCH   = 3'd1;
    localparam logic [2:0] ST_DECODE  = 3'd2;
    localparam logic [2:0] ST_EXECUTE = 3'd3;
    localparam logic [2:0] ST_MEM     = 3'd4;
    localparam logic [2:0] ST_HALTED  = 3'd5;

    // Instruction field positions
    localparam int OP_MSB    = 15;
    localparam int OP_LSB    = 12;
    localparam int RD_MSB    = 11;
    localparam int RD_LSB    = 8;
    localparam int RS1_MSB   = 7;
    localparam int RS1_LSB   = 4;
    localparam int RS2_MSB   = 3;
    localparam int RS2_LSB   = 0;
    localparam int IMM8_MSB  = 7;
    localparam int IMM12_MSB = 11;

    function automatic logic [3:0] f_op(input logic [15:0] ir);
        return ir[OP_MSB:OP_LSB];
    endfunction

    function automatic logic [3:0] f_rd(input logic [15:0] ir);
        return ir[RD_MSB:RD_LSB];
    endfunction

    function automatic logic [3:0] f_rs1(input logic [15:0] ir);
        return ir[RS1_MSB:RS1_LSB];
    endfunction

    function automatic logic [3:0] f_rs2(input logic [15:0] ir);
        return ir[RS2_MSB:RS2_LSB];
    endfunction

    function automatic logic [7:0] f_imm8(input logic [15:0] ir);
        return ir[IMM8_MSB:0];
    endfunction

    function automatic logic [11:0] f_imm12(input logic [15:0] ir);
        return ir[IMM12_MSB:0];
    endfunction

    // True for the opcodes that are computed by the external ALU
    function automatic logic is_alu_op(input logic [3:0] op);
        return (op >= OP_ADD) && (op <= OP_NOT);
    endfunction

endpackage

// File: rtl/reg_file_16x16.sv
// ----------------------------------------------------------------------------
// reg_file_16x16
// Sixteen 16-bit general purpose registers. R0 is an ordinary register.
// Ports:
//   clk, rst_n        clock (rising edge), asynchronous active-low clear
//   raddr1 / rdata1   combinational read port 1
//   raddr2 / rdata2   combinational read port 2
//   we, waddr, wdata  synchronous write port
// ----------------------------------------------------------------------------
module reg_file_16x16
    import cpu_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic [3:0]  raddr1,
    output logic [15:0] rdata1,
    input  logic [3:0]  raddr2,
    output logic [15:0] rdata2,
    input  logic        we,
    input  logic [3:0]  waddr,
    input  logic [15:0] wdata
);

    logic [XLEN-1:0] regs_q [16];
    logic [XLEN-1:0] regs_d [16];

    always_comb begin
        for (int i = 0; i < 16; i++) begin
            regs_d[i] = regs_q[i];
        end
        if (we) begin
            regs_d[waddr] = wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 16; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 16; i++) begin
                regs_q[i] <= regs_d[i];
            end
        end
    end

    assign rdata1 = regs_q[raddr1];
    assign rdata2 = regs_q[raddr2];

endmodule

// File: rtl/instr_sequencer.sv
// ----------------------------------------------------------------------------
// instr_sequencer
// Multi-cycle fetch/decode/execute controller of the 16-bit von Neumann CPU.
// Fetches instructions and data over one shared memory port, owns the
// register file, drives the ALU operands/opcode and latches the ALU zero
// flag for BZ.
// Ports:
//   clk, rst_n                         clock, asynchronous active-low reset
//   mem_req, mem_we, mem_addr,
//   mem_wdata, mem_rdata, mem_ready    shared memory port
//   alu_num1, alu_num2, alu_opcode     ALU operand/opcode drive
//   alu_result, alu_zero               ALU combinational outputs
//   halted                             high once HALT has executed
//
// Memory handshake: mem_req acts as "valid". While mem_req is high, mem_we,
// mem_addr and mem_wdata are held stable; the transaction completes on the
// rising edge where mem_req & mem_ready, and read data is sampled on that
// same edge. mem_ready is ignored while mem_req is low. With mem_req low,
// mem_we and mem_wdata are 0.
// ----------------------------------------------------------------------------
module instr_sequencer
    import cpu_pkg::*;
#(
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        mem_req,
    output logic        mem_we,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_wdata,
    input  logic [15:0] mem_rdata,
    input  logic        mem_ready,
    output logic [15:0] alu_num1,
    output logic [15:0] alu_num2,
    output logic [3:0]  alu_opcode,
    input  logic [15:0] alu_result,
    input  logic        alu_zero,
    output logic        halted
);

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    logic [2:0]  state_q, state_d;
    logic [15:0] pc_q,    pc_d;
    logic [15:0] ir_q,    ir_d;
    logic [15:0] a_q,     a_d;
    logic [15:0] b_q,     b_d;
    logic        zflag_q, zflag_d;

    // Decoded fields of the held instruction
    logic [3:0]  op;
    logic [3:0]  rd;
    logic [3:0]  rs1;
    logic [3:0]  rs2;
    logic [7:0]  imm8;
    logic [11:0] imm12;

    assign op    = f_op(ir_q);
    assign rd    = f_rd(ir_q);
    assign rs1   = f_rs1(ir_q);
    assign rs2   = f_rs2(ir_q);
    assign imm8  = f_imm8(ir_q);
    assign imm12 = f_imm12(ir_q);

    // ------------------------------------------------------------------
    // Register file
    // ------------------------------------------------------------------
    logic [3:0]  rf_raddr2;
    logic [15:0] rf_rdata1;
    logic [15:0] rf_rdata2;
    logic        rf_we;
    logic [15:0] rf_wdata;

    // STORE carries its data register in the rd field, so port 2 reads rd
    // for STORE and rs2 for everything else.
    assign rf_raddr2 = (op == OP_STORE) ? rd : rs2;

    reg_file_16x16 u_reg_file (
        .clk    (clk),
        .rst_n  (rst_n),
        .raddr1 (rs1),
        .rdata1 (rf_rdata1),
        .raddr2 (rf_raddr2),
        .rdata2 (rf_rdata2),
        .we     (rf_we),
        .waddr  (rd),
        .wdata  (rf_wdata)
    );

    // ------------------------------------------------------------------
    // Next-state and datapath update
    // ------------------------------------------------------------------
    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        ir_d     = ir_q;
        a_d      = a_q;
        b_d      = b_q;
        zflag_d  = zflag_q;
        rf_we    = 1'b0;
        rf_wdata = alu_result;

        case (state_q)
            ST_IDLE: begin
                state_d = ST_FETCH;
            end

            ST_FETCH: begin
                if (mem_ready) begin
                    ir_d    = mem_rdata;
                    pc_d    = pc_q + 16'd1;
                    state_d = ST_DECODE;
                end
            end

            ST_DECODE: begin
                a_d     = rf_rdata1;
                b_d     = rf_rdata2;
                state_d = (op == OP_HALT) ? ST_HALTED : ST_EXECUTE;
            end

            ST_EXECUTE: begin
                state_d = ST_FETCH;
                if (is_alu_op(op)) begin
                    rf_we    = 1'b1;
                    rf_wdata = alu_result;
                    zflag_d  = alu_zero;
                end else begin
                    case (op)
                        OP_LDI: begin
                            rf_we    = 1'b1;
                            rf_wdata = {8'h00, imm8};
                        end
                        OP_JMP: begin
                            pc_d = {4'h0, imm12};
                        end
                        OP_BZ: begin
                            // pc already points past the BZ, offset is signed
                            if (zflag_q) begin
                                pc_d = pc_q + {{8{imm8[7]}}, imm8};
                            end
                        end
                        OP_LOAD, OP_STORE: begin
                            state_d = ST_MEM;
                        end
                        default: begin
                            // NOP and the unassigned opcodes do nothing
                        end
                    endcase
                end
            end

            ST_MEM: begin
                if (mem_ready) begin
                    if (op == OP_LOAD) begin
                        rf_we    = 1'b1;
                        rf_wdata = mem_rdata;
                    end
                    state_d = ST_FETCH;
                end
            end

            ST_HALTED: begin
                state_d = ST_HALTED;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            pc_q    <= RESET_PC;
            ir_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            zflag_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            a_q     <= a_d;
            b_q     <= b_d;
            zflag_q <= zflag_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs, decoded purely from state and registers so they stay
    // stable while a memory transaction waits for mem_ready.
    // ------------------------------------------------------------------
    always_comb begin
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        case (state_q)
            ST_FETCH: begin
                mem_req  = 1'b1;
                mem_addr = pc_q;
            end
            ST_MEM: begin
                mem_req  = 1'b1;
                mem_addr = a_q;
                if (op == OP_STORE) begin
                    mem_we    = 1'b1;
                    mem_wdata = b_q;
                end
            end
            default: begin
            end
        endcase
    end

    assign alu_num1   = a_q;
    assign alu_num2   = b_q;
    assign alu_opcode = ((state_q == ST_EXECUTE) && is_alu_op(op)) ? op : ALU_IDLE;
    assign halted     = (state_q == ST_HALTED);

endmodule

// File: tb/tb_instr_sequencer.sv
// ----------------------------------------------------------------------------
// tb_instr_sequencer
// Bench for instr_sequencer: memory/ALU responders, an instruction-level
// reference model that produces the expected memory and ALU traffic, a
// monitor that compares DUT traffic against those queues, and a final report.
// ----------------------------------------------------------------------------
module tb_instr_sequencer;

    // ------------------------------------------------------------------
    // Clock / reset
    // ------------------------------------------------------------------
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic        mem_req, mem_we, mem_ready, alu_zero, halted;
    logic [15:0] mem_addr, mem_wdata, mem_rdata, alu_num1, alu_num2, alu_result;
    logic [3:0]  alu_opcode;

    instr_sequencer #(.RESET_PC(16'h0000)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .mem_ready  (mem_ready),
        .alu_num1   (alu_num1),
        .alu_num2   (alu_num2),
        .alu_opcode (alu_opcode),
        .alu_result (alu_result),
        .alu_zero   (alu_zero),
        .halted     (halted)
    );

    // ------------------------------------------------------------------
    // Bench state
    // ------------------------------------------------------------------
    int checks = 0;
    int errors = 0;

    logic [15:0] mem     [0:65535];
    logic [15:0] ref_mem [0:65535];

    logic [32:0] txn_q[$];   // {we, addr, wdata}
    logic [35:0] alu_q[$];   // {opcode, num1, num2}
    int          exp_cycles;

    int ready_mode;          // 0 always ready, 1 random, 2 never
    int stall_idx;           // transaction index to stall, -1 none
    int stall_rem;
    int txn_idx;
    bit mon_en;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ------------------------------------------------------------------
    // ALU behaviour (external block driven by the DUT)
    // ------------------------------------------------------------------
    function automatic logic [15:0] alu_ref(input logic [3:0] op, input logic [15:0] a,
                                            input logic [15:0] b);
        case (op)
            4'd1:    return a + b;
            4'd2:    return a - b;
            4'd3:    return a & b;
            4'd4:    return a | b;
            4'd5:    return a ^ b;
            4'd6:    return ~a;
            default: return 16'h0000;
        endcase
    endfunction

    assign alu_result = alu_ref(alu_opcode, alu_num1, alu_num2);
    assign alu_zero   = (alu_result == 16'h0000);

    // ------------------------------------------------------------------
    // Reference model: executes the program instruction by instruction and
    // records the memory and ALU traffic the sequencer must produce.
    // ------------------------------------------------------------------
    function automatic void model_run();
        logic [15:0] r [16];
        logic [15:0] pc, ins, a, b, res;
        logic [3:0]  op, rd, rs1, rs2;
        logic        z;
        for (int i = 0; i < 16; i++) r[i] = 16'h0;
        pc = 16'h0000;
        z  = 1'b0;
        exp_cycles = 1;                          // IDLE
        for (int step = 0; step < 2000; step++) begin
            ins = ref_mem[pc];
            txn_q.push_back({1'b0, pc, 16'h0000});
            pc  = pc + 16'd1;
            op  = ins[15:12];
            rd  = ins[11:8];
            rs1 = ins[7:4];
            rs2 = ins[3:0];
            if (op == 4'hF) begin
                exp_cycles += 2;                 // fetch + decode
                return;
            end
            exp_cycles += 3;
            case (op)
                4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6: begin
                    a   = r[rs1];
                    b   = r[rs2];
                    alu_q.push_back({op, a, b});
                    res = alu_ref(op, a, b);
                    r[rd] = res;
                    z   = (res == 16'h0000);
                end
                4'h7: begin
                    exp_cycles += 1;
                    txn_q.push_back({1'b0, r[rs1], 16'h0000});
                    r[rd] = ref_mem[r[rs1]];
                end
                4'h8: begin
                    exp_cycles += 1;
                    txn_q.push_back({1'b1, r[rs1], r[rd]});
                    ref_mem[r[rs1]] = r[rd];
                end
                4'h9: r[rd] = {8'h00, ins[7:0]};
                4'hA: pc = {4'h0, ins[11:0]};
                4'hB: if (z) pc = pc + {{8{ins[7]}}, ins[7:0]};
                default: ;
            endcase
        end
    endfunction

    // ------------------------------------------------------------------
    // Memory responder
    // ------------------------------------------------------------------
    initial begin : responder
        mem_ready = 1'b0;
        mem_rdata = 16'h0;
        forever begin
            @(negedge clk);
            #1;
            mem_rdata = mem[mem_addr];
            if (mem_req && txn_idx == stall_idx && stall_rem > 0) begin
                mem_ready = 1'b0;
                stall_rem--;
            end else if (ready_mode == 1) begin
                mem_ready = ($urandom_range(0, 3) != 0);
            end else if (ready_mode == 2) begin
                mem_ready = 1'b0;
            end else begin
                mem_ready = 1'b1;
            end
            if (rst_n && mem_req && mem_ready) begin
                if (mem_we) mem[mem_addr] = mem_wdata;
                txn_idx++;
            end
        end
    end

    // ------------------------------------------------------------------
    // Monitor / scoreboard
    // ------------------------------------------------------------------
    initial begin : monitor
        logic        prev_wait;
        logic [32:0] prev_vec;
        logic [32:0] exp;
        prev_wait = 1'b0;
        prev_vec  = '0;
        forever begin
            @(negedge clk);
            #2;
            if (mon_en && rst_n) begin
                if (prev_wait)
                    check("wait_stable", {mem_req, mem_we, mem_addr, mem_wdata}, {1'b1, prev_vec});
                if (!mem_req)
                    check("idle_bus", {mem_we, mem_wdata}, 17'h0);
                if (mem_req && mem_ready) begin
                    if (txn_q.size() == 0) begin
                        check("txn_extra", {mem_we, mem_addr}, 17'h1FFFF ^ {mem_we, mem_addr} );
                    end else begin
                        exp = txn_q.pop_front();
                        if (exp[32])
                            check("mem_write", {mem_we, mem_addr, mem_wdata}, exp);
                        else
                            check("mem_read", {mem_we, mem_addr}, exp[32:16]);
                    end
                end
                if (alu_opcode != 4'h0) begin
                    if (alu_q.size() == 0)
                        check("alu_extra", alu_opcode, 4'h0);
                    else
                        check("alu_drive", {alu_opcode, alu_num1, alu_num2}, alu_q.pop_front());
                end
                prev_wait = mem_req && !mem_ready;
                prev_vec  = {mem_we, mem_addr, mem_wdata};
            end else begin
                prev_wait = 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Driver tasks
    // ------------------------------------------------------------------
    task automatic clear_mem();
        for (int a = 0; a < 65536; a++) mem[a] = 16'h0000;
    endtask

    task automatic run_program(input int mode, input int stall_at, input bit check_cycles);
        int n;
        int bad;
        @(negedge clk);
        mon_en = 1'b0;
        rst_n  = 1'b0;
        #1;
        check("reset_outputs",
              {mem_req, mem_we, mem_addr, mem_wdata, alu_num1, alu_num2, alu_opcode, halted},
              71'h0);
        for (int a = 0; a < 65536; a++) ref_mem[a] = mem[a];
        txn_q.delete();
        alu_q.delete();
        model_run();
        ready_mode = mode;
        stall_idx  = stall_at;
        stall_rem  = 3;
        txn_idx    = 0;
        @(negedge clk);
        rst_n  = 1'b1;
        mon_en = 1'b1;
        n = 0;
        while (n < 4000) begin
            @(posedge clk);
            n++;
            #1;
            if (halted) break;
        end
        check("halt_reached", halted, 1'b1);
        if (check_cycles)
            check("cycles", n, exp_cycles + ((stall_at >= 0) ? 3 : 0));
        bad = 0;
        repeat (25) begin
            @(negedge clk);
            #2;
            if (!(halted && !mem_req && !mem_we && mem_wdata == 16'h0)) bad++;
        end
        check("halted_quiet", bad, 0);
        check("txn_left", txn_q.size(), 0);
        check("alu_left", alu_q.size(), 0);
        bad = 0;
        for (int a = 0; a < 256; a++) if (mem[a] !== ref_mem[a]) bad++;
        check("mem_image", bad, 0);
        mon_en = 1'b0;
    endtask

    task automatic load_load_add();
        clear_mem();
        mem[0]  = 16'h9490;   // LDI R4,0x90
        mem[1]  = 16'h7540;   // LOAD R5,[R4]
        mem[2]  = 16'h9605;   // LDI R6,5
        mem[3]  = 16'h1756;   // ADD R7,R5,R6
        mem[4]  = 16'hB001;   // BZ +1
        mem[5]  = 16'h9822;   // LDI R8,0x22 (skipped when zflag set)
        mem[6]  = 16'h99A0;   // LDI R9,0xA0
        mem[7]  = 16'h8790;   // STORE R7,[R9]
        mem[8]  = 16'h99A1;   // LDI R9,0xA1
        mem[9]  = 16'h8590;   // STORE R5,[R9]
        mem[10] = 16'hF000;   // HALT
        mem[16'h0090] = 16'hFFFB;
        mem[16'h00A0] = 16'h5555;
    endtask

    task automatic gen_random_program();
        int i;
        logic [3:0] op, rd, rs1, rs2, rx;
        clear_mem();
        for (int a = 0; a < 128; a++) mem[a] = 16'hF000;
        for (int a = 128; a < 256; a++) mem[a] = 16'($urandom);
        i = 0;
        while (i < 16'h70) begin
            rd  = 4'($urandom_range(0, 15));
            rs1 = 4'($urandom_range(0, 15));
            rs2 = 4'($urandom_range(0, 15));
            rx  = 4'($urandom_range(0, 15));
            case ($urandom_range(0, 9))
                0, 1, 2: begin
                    op = 4'($urandom_range(1, 6));
                    mem[i] = {op, rd, rs1, rs2};
                end
                3: mem[i] = {4'h9, rd, 8'($urandom)};
                4: begin
                    op = 4'($urandom_range(0, 3));
                    if (op != 4'h0) op = op + 4'hB;      // 0 or C..E
                    mem[i] = {op, rd, rs1, rs2};
                end
                5: begin
                    mem[i] = {4'h9, rx, 1'b1, 7'($urandom)};
                    i++;
                    mem[i] = {4'h7, rd, rx, rs2};
                end
                6: begin
                    mem[i] = {4'h9, rx, 1'b1, 7'($urandom)};
                    i++;
                    mem[i] = {4'h8, rd, rx, rs2};
                end
                7: mem[i] = {4'hB, rd, 8'($urandom_range(0, 3))};
                8: mem[i] = {4'hA, 12'(i + 1 + $urandom_range(0, 3))};
                default: mem[i] = {4'h2, rd, rs1, rs1};
            endcase
            i++;
        end
    endtask

    // ------------------------------------------------------------------
    // Test sequence
    // ------------------------------------------------------------------
    initial begin : main
        rst_n      = 1'b0;
        ready_mode = 0;
        stall_idx  = -1;
        stall_rem  = 0;
        txn_idx    = 0;
        mon_en     = 1'b0;
        clear_mem();
        repeat (2) @(negedge clk);
        #1;
        check("por_outputs",
              {mem_req, mem_we, mem_addr, mem_wdata, alu_num1, alu_num2, alu_opcode, halted},
              71'h0);

        // Reset while a fetch is waiting for mem_ready
        mem[0] = 16'h9109;
        mem[1] = 16'h9203;
        mem[2] = 16'hF000;
        stall_idx = 2;
        stall_rem = 1000;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        #2;
        check("stalled_fetch", {mem_req, mem_we, mem_addr}, {1'b1, 1'b0, 16'h0002});
        #1;
        rst_n = 1'b0;
        #1;
        check("async_reset", {mem_req, mem_we, mem_addr, alu_num1, alu_num2, alu_opcode, halted}, 54'h0);
        stall_idx = -1;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("first_fetch", {mem_req, mem_we, mem_addr}, {1'b1, 1'b0, 16'h0000});

        // ADD/STORE
        clear_mem();
        mem[0] = 16'h9109;   // LDI R1,9
        mem[1] = 16'h9203;   // LDI R2,3
        mem[2] = 16'h1312;   // ADD R3,R1,R2
        mem[3] = 16'h9480;   // LDI R4,0x80
        mem[4] = 16'h8340;   // STORE R3,[R4]
        mem[5] = 16'hF000;
        run_program(0, -1, 1);
        check("add_store_value", mem[16'h0080], 16'h000C);

        // BZ taken (zflag=1) then not taken (zflag=0)
        clear_mem();
        mem[0] = 16'h9105;   // LDI R1,5
        mem[1] = 16'h2211;   // SUB R2,R1,R1
        mem[2] = 16'hB002;   // BZ +2
        mem[3] = 16'h9AAA;
        mem[4] = 16'h9BBB;
        mem[5] = 16'hF000;
        run_program(0, -1, 1);
        mem[1] = 16'h2210;   // SUB R2,R1,R0
        run_program(0, -1, 1);

        // LOAD/ADD, then with a 3-cycle stall in FETCH and in LOAD's MEM
        load_load_add();
        run_program(0, -1, 1);
        check("load_add_r7", mem[16'h00A0], 16'h0000);
        check("load_add_r5", mem[16'h00A1], 16'hFFFB);
        load_load_add();
        run_program(0, 0, 1);
        load_load_add();
        run_program(0, 2, 1);

        // JMP onto a HALT
        clear_mem();
        mem[0] = 16'hA010;
        for (int a = 1; a < 16; a++) mem[a] = 16'h9F01;
        mem[16'h0010] = 16'hF000;
        run_program(0, -1, 1);

        // Randomized programs
        for (int k = 0; k < 8; k++) begin
            gen_random_program();
            if (k < 2) run_program(0, -1, 1);
            else       run_program(1, -1, 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
